flash_usb_dumper: RTL and testbench

//  Transmit side of the USB link. Reads an inclusive range of 16-bit words from flash

---
 rtl/usb_defs.sv | 18 +
 rtl/usb_output.sv | 51 +++++
 rtl/flash_usb_dumper.sv | 108 ++++++++++
 tb/tb_flash_usb_dumper.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_defs.sv
// usb_defs: FT245 timing defaults, flash read latency and FSM state encodings shared by the USB blocks
package usb_defs;
  localparam int DEF_READ_LAT   = 8;
  localparam int DEF_WR_HIGH    = 2;
  localparam int DEF_TXE_SETTLE = 4;
  localparam bit DEF_SEND_LOW   = 1'b1;
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ADDR   = 4'd1,
    RDWAIT = 4'd2,
    TXWAIT = 4'd3,
    SETUP  = 4'd4,
    STROBE = 4'd5,
    HOLD   = 4'd6,
    SETTLE = 4'd7,
    DONE   = 4'd8
  } state_t;
endpackage

// File: rtl/usb_output.sv
// usb_output: FT245 byte transmitter (in/newin load a byte, ready = free at next edge; data/oe/wr drive the FIFO, txe active low)
module usb_output
  import usb_defs::*;
#(
  parameter int WR_HIGH    = DEF_WR_HIGH,
  parameter int TXE_SETTLE = DEF_TXE_SETTLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       newin,
  output logic       ready,
  output logic [7:0] data,
  output logic       oe,
  input  logic       txe,
  output logic       wr
);
  state_t st, nxt;
  logic [7:0] cnt;
  logic settle_end;
  // ready is also high on the last SETTLE cycle so the next byte follows with no gap
  always_comb begin
    settle_end = cnt == 8'(TXE_SETTLE - 1);
    ready = st == IDLE || (st == SETTLE && settle_end);
    nxt = st;
    case (st)
      IDLE:    nxt = newin ? TXWAIT : IDLE;
      TXWAIT:  nxt = txe ? TXWAIT : SETUP;
      SETUP:   nxt = STROBE;
      STROBE:  nxt = cnt == 8'(WR_HIGH - 1) ? HOLD : STROBE;
      HOLD:    nxt = SETTLE;
      SETTLE:  nxt = settle_end ? (newin ? TXWAIT : IDLE) : SETTLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      cnt <= 8'd0;
      data <= 8'd0;
      oe <= 1'b0;
      wr <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= nxt == st ? cnt + 8'd1 : 8'd0;
      if (ready && newin) data <= in;
      oe <= nxt != IDLE;
      wr <= nxt == STROBE;
    end
  end
endmodule

// File: rtl/flash_usb_dumper.sv
// flash_usb_dumper: streams flash words start_addr..end_addr to the FT245 FIFO; start/abort control, active/done/words_sent status, flash_manager read port (writemode, doread, raddr, frdata, busy), FIFO port (usb_data, usb_data_oe, txe, wr), debug state
module flash_usb_dumper
  import usb_defs::*;
#(
  parameter int READ_LAT   = DEF_READ_LAT,
  parameter int WR_HIGH    = DEF_WR_HIGH,
  parameter int TXE_SETTLE = DEF_TXE_SETTLE,
  parameter bit SEND_LOW   = DEF_SEND_LOW
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [22:0] start_addr,
  input  logic [22:0] end_addr,
  input  logic        abort,
  output logic        active,
  output logic        done,
  output logic [22:0] words_sent,
  output logic        writemode,
  output logic        doread,
  output logic [22:0] raddr,
  input  logic [15:0] frdata,
  input  logic        busy,
  output logic [7:0]  usb_data,
  output logic        usb_data_oe,
  input  logic        txe,
  output logic        wr,
  output logic [3:0]  state
);
  state_t st, nxt;
  logic [22:0] cur, last_addr;
  logic [7:0] cnt, lo, tx_in;
  logic lo_sel, abort_p, ab, word_end, newin, ready;
  assign writemode = 1'b0;
  assign doread = active;
  assign state = st;
  // TXWAIT here means a byte is owned by the transmitter; ready marks its final cycle
  always_comb begin
    ab = abort_p | abort;
    word_end = lo_sel | !SEND_LOW;
    newin = 1'b0;
    tx_in = frdata[15:8];
    nxt = st;
    case (st)
      IDLE:   nxt = start ? (end_addr < start_addr ? DONE : ADDR) : IDLE;
      ADDR:   nxt = ab ? DONE : RDWAIT;
      RDWAIT: if (!busy && cnt == 8'(READ_LAT - 1)) begin
        newin = !ab;
        nxt = ab ? DONE : TXWAIT;
      end
      TXWAIT: if (ready) begin
        newin = !word_end && !ab;
        tx_in = lo;
        nxt = newin ? TXWAIT : (word_end && !ab && cur != last_addr) ? ADDR : DONE;
      end
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st <= IDLE;
      cur <= 23'd0;
      last_addr <= 23'd0;
      cnt <= 8'd0;
      lo <= 8'd0;
      lo_sel <= 1'b0;
      abort_p <= 1'b0;
      active <= 1'b0;
      done <= 1'b0;
      words_sent <= 23'd0;
      raddr <= 23'd0;
    end else begin
      st <= nxt;
      abort_p <= st == IDLE ? abort : ab;
      cnt <= st == RDWAIT && !busy ? cnt + 8'd1 : 8'd0;
      done <= st == DONE;
      if (st == IDLE && start) begin
        cur <= start_addr;
        last_addr <= end_addr;
        words_sent <= 23'd0;
        active <= 1'b1;
      end
      if (st == DONE) active <= 1'b0;
      if (st == ADDR) raddr <= cur;
      if (st == RDWAIT && newin) begin
        lo <= frdata[7:0];
        lo_sel <= 1'b0;
      end
      if (st == TXWAIT && newin) lo_sel <= 1'b1;
      if (st == TXWAIT && ready && word_end) begin
        words_sent <= words_sent + 23'd1;
        if (nxt == ADDR) cur <= cur + 23'd1;
      end
    end
  end
  usb_output #(.WR_HIGH(WR_HIGH), .TXE_SETTLE(TXE_SETTLE)) u_out (
    .clk(clock),
    .reset(reset),
    .in(tx_in),
    .newin(newin),
    .ready(ready),
    .data(usb_data),
    .oe(usb_data_oe),
    .txe(txe),
    .wr(wr)
  );
endmodule

// File: tb/tb_flash_usb_dumper.sv
// tb_flash_usb_dumper: directed self-checking bench for flash_usb_dumper (default and high-byte-only builds)
module tb_flash_usb_dumper;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, start0 = 1'b0, abort = 1'b0, txe = 1'b0, busy = 1'b0;
  logic [22:0] start_addr = 23'd0, end_addr = 23'd0;
  logic active, done, writemode, doread, usb_data_oe, wr;
  logic active0, done0, writemode0, doread0, usb_data_oe0, wr0;
  logic [22:0] words_sent, raddr, words_sent0, raddr0;
  logic [15:0] frdata, frdata0;
  logic [7:0] usb_data, usb_data0;
  logic [3:0] state, state0;
  int n_chk = 0, n_err = 0, dn = 0, lat = 0, first_wr = 0, stab_err = 0, hi_len = 0;
  logic d_after, snap_oe, raddr_zero, p_wr = 1'b0, wr_seen;
  logic [7:0] snap_d, p_data = 8'd0;
  logic [7:0] q[$], q0[$], exp_q[$];

  always #5 clock = ~clock;

  // flash model: word = addr * 0x0101 (truncated to 16 bits)
  assign frdata = raddr[15:0] * 16'h0101;
  assign frdata0 = raddr0[15:0] * 16'h0101;

  flash_usb_dumper dut (
    .clock(clock), .reset(reset), .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .abort(abort), .active(active), .done(done), .words_sent(words_sent), .writemode(writemode),
    .doread(doread), .raddr(raddr), .frdata(frdata), .busy(busy), .usb_data(usb_data),
    .usb_data_oe(usb_data_oe), .txe(txe), .wr(wr), .state(state)
  );

  flash_usb_dumper #(.SEND_LOW(1'b0)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .start_addr(start_addr), .end_addr(end_addr),
    .abort(abort), .active(active0), .done(done0), .words_sent(words_sent0), .writemode(writemode0),
    .doread(doread0), .raddr(raddr0), .frdata(frdata0), .busy(busy), .usb_data(usb_data0),
    .usb_data_oe(usb_data_oe0), .txe(txe), .wr(wr0), .state(state0)
  );

  always @(negedge wr) q.push_back(usb_data);
  always @(negedge wr0) q0.push_back(usb_data0);
  always @(negedge clock) if (done) dn++;

  // data must hold from the cycle before wr rises through the cycle after it falls; wr high exactly 2 cycles
  always @(negedge clock) begin
    if ((wr0 || p_wr) && usb_data0 !== p_data) stab_err++;
    if (!wr0 && p_wr && hi_len != 2) stab_err++;
    hi_len = wr0 ? hi_len + 1 : 0;
    p_wr = wr0;
    p_data = usb_data0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmp_bytes(input string tag, input bit sel);
    check({tag, "_count"}, sel ? q0.size() : q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "_byte"}, sel ? q0[i] : q[i], {24'd0, exp_q[i]});
  endtask

  // one run: bm/am give busy/abort per cycle (bit n = cycle n after start), txe=1 for cycles < txe_until
  task automatic run(input bit sel, input logic [22:0] sa, input logic [22:0] ea,
                     input logic [31:0] bm, input logic [31:0] am, input int txe_until);
    int n;
    start_addr = sa;
    end_addr = ea;
    q.delete();
    q0.delete();
    dn = 0;
    first_wr = 0;
    raddr_zero = 1'b0;
    @(negedge clock);
    if (sel) start0 = 1'b1; else start = 1'b1;
    abort = am[0];
    busy = bm[0];
    txe = txe_until > 0;
    @(negedge clock);
    start = 1'b0;
    start0 = 1'b0;
    n = 1;
    forever begin
      abort = n < 32 ? am[n] : 1'b0;
      busy = n < 32 ? bm[n] : 1'b0;
      txe = n < txe_until;
      if (wr && first_wr == 0) first_wr = n;
      if (n == 59) begin
        snap_oe = usb_data_oe;
        snap_d = usb_data;
      end
      if (n >= 2 && raddr == 23'd0) raddr_zero = 1'b1;
      if ((sel ? done0 : done) || n >= 3000) break;
      @(negedge clock);
      n++;
    end
    lat = n;
    abort = 1'b0;
    busy = 1'b0;
    txe = 1'b0;
    @(negedge clock);
    d_after = sel ? done0 : done;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    check("rst_words", words_sent, 0);
    check("rst_writemode", writemode, 0);
    check("rst_doread", doread, 0);
    check("rst_raddr", raddr, 0);
    check("rst_usb_data", usb_data, 0);
    check("rst_oe", usb_data_oe, 0);
    check("rst_wr", wr, 0);
    check("rst_state", state, 0);
    reset = 1'b0;
    @(negedge clock);

    run(1'b0, 23'd10, 23'd12, 32'd0, 32'd0, 0);
    exp_q = '{8'h0A, 8'h0A, 8'h0B, 8'h0B, 8'h0C, 8'h0C};
    cmp_bytes("t1", 1'b0);
    check("t1_words", words_sent, 3);
    check("t1_latency", lat, 83);
    check("t1_done_once", dn, 1);
    check("t1_done_pulse", d_after, 0);
    check("t1_active_off", active, 0);
    check("t1_writemode", writemode, 0);

    run(1'b1, 23'd5, 23'd6, 32'd0, 32'd0, 0);
    exp_q = '{8'h05, 8'h06};
    cmp_bytes("t2", 1'b1);
    check("t2_words", words_sent0, 2);
    check("t2_latency", lat, 38);
    check("t2_stable_width", stab_err, 0);

    run(1'b0, 23'd30, 23'd30, 32'd0, 32'd0, 60);
    check("t3_oe_waiting", snap_oe, 1);
    check("t3_data_waiting", snap_d, 8'h1E);
    check("t3_first_wr", first_wr, 62);
    check("t3_latency", lat, 79);
    exp_q = '{8'h1E, 8'h1E};
    cmp_bytes("t3", 1'b0);

    run(1'b0, 23'd20, 23'd20, 32'h0000_0168, 32'd0, 0);
    check("t4_latency", lat, 36);
    check("t4_words", words_sent, 1);
    exp_q = '{8'h14, 8'h14};
    cmp_bytes("t4", 1'b0);

    run(1'b0, 23'd4, 23'd3, 32'd0, 32'd0, 0);
    check("t5_latency", lat, 2);
    check("t5_words", words_sent, 0);
    check("t5_no_wr", q.size(), 0);

    run(1'b0, 23'h7FFFFE, 23'h7FFFFF, 32'd0, 32'd0, 0);
    check("t5b_words", words_sent, 2);
    check("t5b_no_wrap", raddr_zero, 0);
    check("t5b_raddr", raddr, 23'h7FFFFF);
    check("t5b_latency", lat, 56);
    exp_q = '{8'hFD, 8'hFE, 8'hFE, 8'hFF};
    cmp_bytes("t5b", 1'b0);

    run(1'b0, 23'd0, 23'd9, 32'd0, 32'h0000_1000, 0);
    check("t6_latency", lat, 20);
    check("t6_words", words_sent, 0);
    check("t6_done_once", dn, 1);
    exp_q = '{8'h00};
    cmp_bytes("t6", 1'b0);

    run(1'b0, 23'd0, 23'd9, 32'd0, 32'h0000_0001, 0);
    check("t6b_latency", lat, 3);
    check("t6b_words", words_sent, 0);
    check("t6b_no_wr", q.size(), 0);

    start_addr = 23'd0;
    end_addr = 23'd9;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wr_seen = 1'b0;
    for (int i = 0; i < 200 && !wr_seen; i++) begin
      @(negedge clock);
      wr_seen = wr;
    end
    check("t6c_strobe_seen", wr_seen, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("t6c_wr_dropped", wr, 0);
    check("t6c_state_idle", state, 0);
    check("t6c_active", active, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
